// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state, width and byte-select definitions for the SRAM sequencer
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACC   = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } mem_state_t;

  localparam int WAIT_CNT_W = 4;

  // Byte-select encodings and lane positions within Byte_sel
  localparam logic [1:0] BSEL_NONE = 2'b00;
  localparam logic [1:0] BSEL_BOTH = 2'b11;
  localparam int         UB_BIT    = 1;
  localparam int         LB_BIT    = 0;

  // An all-zero byte select would make the access a no-op; treat it as a full word
  function automatic logic [1:0] norm_byte_sel(input logic [1:0] sel);
    return (sel == BSEL_NONE) ? BSEL_BOTH : sel;
  endfunction

endpackage

// File: rtl/tri_buffer_16.sv
// rtl/tri_buffer_16.sv - 16-bit tri-state bus driver
module tri_buffer_16 (
  input  logic [15:0] d,
  input  logic        en,
  inout  wire  [15:0] bus
);

  assign bus = en ? d : 16'hzzzz;

endmodule

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable down-counter with terminal-count flag
module wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  tc
);

  logic [WAIT_CNT_W-1:0] count;

  // Load wins over decrement; the count parks at zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WAIT_CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - single-word async SRAM access sequencer for the ISDU/MAR/MDR datapath
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
)
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rd_req,
  input  logic        Wr_req,
  input  logic [15:0] Addr_in,
  input  logic [15:0] Wr_data,
  input  logic [1:0]  Byte_sel,
  output logic [15:0] Rd_data,
  output logic        R,
  output logic        Busy,
  output logic        Err,
  output logic [15:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE
);

  mem_state_t  state;
  logic [1:0]  byte_en;
  logic [15:0] wr_buf;
  logic        data_oe;
  logic [1:0]  sel_norm;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_tc;

  assign sel_norm = norm_byte_sel(Byte_sel);

  // The counter is armed on entry to the two timed states and counts down inside them
  assign cnt_load = ((state == IDLE) && Rd_req) || (state == WR_SETUP);
  assign cnt_dec  = (state == RD_ACC) || (state == WR_PULSE);

  wait_counter u_wait_counter (
    .clk      (Clk),
    .resetn   (Reset),
    .load     (cnt_load),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES - 1)),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  tri_buffer_16 u_data_buf (
    .d   (wr_buf),
    .en  (data_oe),
    .bus (Data)
  );

  // Sequencer: pin controls are registered together with the state they belong to
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      ADDR    <= 16'h0000;
      Rd_data <= 16'h0000;
      wr_buf  <= 16'h0000;
      byte_en <= BSEL_BOTH;
      R       <= 1'b0;
      Busy    <= 1'b0;
      Err     <= 1'b0;
      CE      <= 1'b1;
      UB      <= 1'b1;
      LB      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      data_oe <= 1'b0;
    end else begin
      R   <= 1'b0;
      Err <= 1'b0;
      case (state)
        IDLE: begin
          if (Rd_req) begin
            state   <= RD_ACC;
            ADDR    <= Addr_in;
            byte_en <= sel_norm;
            Err     <= Wr_req;
            Busy    <= 1'b1;
            CE      <= 1'b0;
            OE      <= 1'b0;
            UB      <= ~sel_norm[UB_BIT];
            LB      <= ~sel_norm[LB_BIT];
          end else if (Wr_req) begin
            state   <= WR_SETUP;
            ADDR    <= Addr_in;
            byte_en <= sel_norm;
            wr_buf  <= Wr_data;
            Busy    <= 1'b1;
            CE      <= 1'b0;
            UB      <= ~sel_norm[UB_BIT];
            LB      <= ~sel_norm[LB_BIT];
            data_oe <= 1'b1;
          end
        end
        RD_ACC: begin
          if (cnt_tc) begin
            state   <= DONE;
            Rd_data <= {byte_en[UB_BIT] ? Data[15:8] : 8'h00,
                        byte_en[LB_BIT] ? Data[7:0]  : 8'h00};
            CE      <= 1'b1;
            OE      <= 1'b1;
            UB      <= 1'b1;
            LB      <= 1'b1;
            R       <= 1'b1;
          end
        end
        WR_SETUP: begin
          state <= WR_PULSE;
          WE    <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt_tc) begin
            state <= WR_HOLD;
            WE    <= 1'b1;
          end
        end
        WR_HOLD: begin
          state   <= DONE;
          CE      <= 1'b1;
          UB      <= 1'b1;
          LB      <= 1'b1;
          data_oe <= 1'b0;
          R       <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          Busy    <= 1'b0;
          CE      <= 1'b1;
          UB      <= 1'b1;
          LB      <= 1'b1;
          OE      <= 1'b1;
          WE      <= 1'b1;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - self-checking bench for sram_mem_ctrl with async SRAM models
module tb_sram_mem_ctrl;

  localparam int W_A = 2;
  localparam int W_B = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic        use_b = 1'b0;
  logic [15:0] addr_in = 16'h0000;
  logic [15:0] wr_data = 16'h0000;
  logic [1:0]  byte_sel = 2'b11;

  logic        rd_a, wr_a, rd_b, wr_b;
  logic [15:0] rd_data_a, rd_data_b, addr_a, addr_b;
  logic        r_a, r_b, busy_a, busy_b, err_a, err_b;
  logic        ce_a, ub_a, lb_a, oe_a, we_a;
  logic        ce_b, ub_b, lb_b, oe_b, we_b;
  wire  [15:0] data_a;
  wire  [15:0] data_b;

  logic [15:0] sram_a [0:65535];
  logic [15:0] sram_b [0:65535];
  logic [15:0] ref_mem [int];

  int n_checks = 0;
  int n_fail = 0;
  int viol = 0;

  always #5 clk = ~clk;

  assign rd_a = rd_req & ~use_b;
  assign wr_a = wr_req & ~use_b;
  assign rd_b = rd_req & use_b;
  assign wr_b = wr_req & use_b;

  sram_mem_ctrl #(.WAIT_CYCLES(W_A)) dut_a (
    .Clk(clk), .Reset(resetn), .Rd_req(rd_a), .Wr_req(wr_a), .Addr_in(addr_in),
    .Wr_data(wr_data), .Byte_sel(byte_sel), .Rd_data(rd_data_a), .R(r_a), .Busy(busy_a),
    .Err(err_a), .ADDR(addr_a), .Data(data_a), .CE(ce_a), .UB(ub_a), .LB(lb_a),
    .OE(oe_a), .WE(we_a)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(W_B)) dut_b (
    .Clk(clk), .Reset(resetn), .Rd_req(rd_b), .Wr_req(wr_b), .Addr_in(addr_in),
    .Wr_data(wr_data), .Byte_sel(byte_sel), .Rd_data(rd_data_b), .R(r_b), .Busy(busy_b),
    .Err(err_b), .ADDR(addr_b), .Data(data_b), .CE(ce_b), .UB(ub_b), .LB(lb_b),
    .OE(oe_b), .WE(we_b)
  );

  // Async SRAM models: drive on CE/OE low with WE high, write selected lanes while WE low
  assign data_a = (!ce_a && !oe_a && we_a) ? sram_a[addr_a] : 16'hzzzz;
  assign data_b = (!ce_b && !oe_b && we_b) ? sram_b[addr_b] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_a && !we_a) begin
      if (!ub_a) sram_a[addr_a][15:8] = data_a[15:8];
      if (!lb_a) sram_a[addr_a][7:0]  = data_a[7:0];
    end
    if (!ce_b && !we_b) begin
      if (!ub_b) sram_b[addr_b][15:8] = data_b[15:8];
      if (!lb_b) sram_b[addr_b][7:0]  = data_b[7:0];
    end
  end

  // Bus protocol monitor: OE/WE never both low, controller never drives while OE low
  always @(negedge clk) begin
    if (resetn) begin
      if (!oe_a && !we_a) viol++;
      if (!oe_b && !we_b) viol++;
      if (!oe_a && dut_a.data_oe) viol++;
      if (!oe_b && dut_b.data_oe) viol++;
    end
  end

  logic        m_r, m_busy, m_err, m_oe, m_we;
  logic [15:0] m_rd_data, m_addr;
  assign m_r       = use_b ? r_b : r_a;
  assign m_busy    = use_b ? busy_b : busy_a;
  assign m_err     = use_b ? err_b : err_a;
  assign m_oe      = use_b ? oe_b : oe_a;
  assign m_we      = use_b ? we_b : we_a;
  assign m_rd_data = use_b ? rd_data_b : rd_data_a;
  assign m_addr    = use_b ? addr_b : addr_a;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [1:0] eff_sel(input logic [1:0] s);
    return (s == 2'b00) ? 2'b11 : s;
  endfunction

  function automatic logic [15:0] lane_mask(input logic [15:0] v, input logic [1:0] s);
    logic [1:0] e;
    e = eff_sel(s);
    return {e[1] ? v[15:8] : 8'h00, e[0] ? v[7:0] : 8'h00};
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] s);
    logic [15:0] cur;
    logic [1:0]  e;
    cur = ref_read(a);
    e = eff_sel(s);
    if (e[1]) cur[15:8] = wd[15:8];
    if (e[0]) cur[7:0]  = wd[7:0];
    ref_mem[int'(a)] = cur;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One access from an IDLE negedge; returns at the IDLE negedge following R
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] sel, output int lat, output int oe_low, output int we_low,
                        output int first_we, output int last_we, output int err_cnt);
    bit seen;
    lat = -1; oe_low = 0; we_low = 0; first_we = -1; last_we = -1; err_cnt = 0; seen = 0;
    rd_req = rd; wr_req = wr; addr_in = a; wr_data = wd; byte_sel = sel;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    check("accept_busy", 32'(m_busy), 32'd1);
    for (int k = 0; k < 40 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (!m_oe) oe_low++;
      if (!m_we) begin
        we_low++;
        if (first_we < 0) first_we = k;
        last_we = k;
      end
      if (m_err) err_cnt++;
      if (m_r) begin
        lat = k + 1;
        seen = 1;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [1:0]  sel;
    logic [15:0] exp_rd;
    int          exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, oel, wel, fw, lw, ec, rcount;
    logic [15:0] exp_rd, a, wd;
    logic [1:0]  sel;
    logic        rd, wr;
    int          op;

    for (int i = 0; i < 65536; i++) begin
      sram_a[i] = init_val(16'(i));
      sram_b[i] = init_val(16'(i));
    end
    sram_a[16'h3000] = 16'hBEEF;

    vecs[0]  = '{1'b1, 1'b0, 16'h3000, 16'h0000, 2'b11, 16'hBEEF, 0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, 16'hBEEF, 0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'hA534, 0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b10, 16'hA500, 0};
    vecs[4]  = '{1'b1, 1'b0, 16'h3000, 16'h0000, 2'b00, 16'hBEEF, 0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0020, 16'hCAFE, 2'b10, 16'hBEEF, 0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'hCAE3, 0};
    vecs[7]  = '{1'b1, 1'b1, 16'h0010, 16'hFFFF, 2'b11, 16'hA534, 1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'hA534, 0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0030, 16'h1357, 2'b00, 16'hA534, 0};
    vecs[10] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 2'b01, 16'h0057, 0};

    // Reset state after five idle cycles
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_ctrl_pins", 32'({ce_a, ub_a, lb_a, oe_a, we_a}), 32'h1f);
    check("rst_r", 32'(r_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_addr", 32'(addr_a), 32'h0);
    check("rst_rd_data", 32'(rd_data_a), 32'h0);
    check("rst_data_z", 32'(dut_a.data_oe), 32'd0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].sel, lat, oel, wel, fw, lw, ec);
      check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].rd ? 32'(W_A + 1) : 32'(W_A + 3));
      check($sformatf("v%0d_rd_data", i), 32'(m_rd_data), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_err", i), 32'(ec), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_addr", i), 32'(m_addr), 32'(vecs[i].addr));
      if (vecs[i].rd) begin
        check($sformatf("v%0d_oe_low", i), 32'(oel), 32'(W_A));
        check($sformatf("v%0d_we_low", i), 32'(wel), 32'd0);
      end else begin
        check($sformatf("v%0d_we_low", i), 32'(wel), 32'(W_A));
        check($sformatf("v%0d_we_first", i), 32'(fw), 32'd1);
        check($sformatf("v%0d_we_last", i), 32'(lw), 32'(W_A));
        check($sformatf("v%0d_oe_low", i), 32'(oel), 32'd0);
      end
    end
    check("mem_0010_lower_write", 32'(sram_a[16'h0010]), 32'hA534);

    // Write request held during a busy read is ignored
    rd_req = 1'b1; addr_in = 16'h3000; byte_sel = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b1; addr_in = 16'h0040; wr_data = 16'hDEAD;
    for (int k = 0; k < 20 && !r_a; k++) @(negedge clk);
    check("busy_rd_r", 32'(r_a), 32'd1);
    wr_req = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_wr_idle", 32'(busy_a), 32'd0);
    check("busy_wr_mem", 32'(sram_a[16'h0040]), 32'(init_val(16'h0040)));
    check("busy_wr_rd_data", 32'(rd_data_a), 32'hBEEF);

    // Reset during the write pulse
    wr_req = 1'b1; addr_in = 16'h0050; wr_data = 16'h7777; byte_sel = 2'b11;
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0;
    check("mr_setup_we", 32'({ce_a, we_a}), 32'b01);
    @(negedge clk);
    check("mr_pulse_we", 32'(we_a), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    check("mr_we_high", 32'(we_a), 32'd1);
    check("mr_data_z", 32'(dut_a.data_oe), 32'd0);
    check("mr_busy", 32'(busy_a), 32'd0);
    check("mr_ce", 32'(ce_a), 32'd1);
    resetn = 1'b1;
    rcount = 0;
    for (int k = 0; k < 6; k++) begin
      if (r_a) rcount++;
      @(negedge clk);
    end
    check("mr_no_r", 32'(rcount), 32'd0);
    check("mr_rd_data_cleared", 32'(rd_data_a), 32'h0);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, lat, oel, wel, fw, lw, ec);
    check("mr_read_latency", 32'(lat), 32'(W_A + 1));
    check("mr_read_data", 32'(rd_data_a), 32'hA534);

    // Randomized accesses in an untouched region against the reference image
    exp_rd = rd_data_a;
    for (int i = 0; i < 40; i++) begin
      a   = 16'h0400 + 16'($urandom_range(0, 7));
      op  = int'($urandom_range(0, 9));
      sel = 2'($urandom_range(0, 3));
      wd  = 16'($urandom);
      rd  = (op < 5) || (op == 9);
      wr  = (op >= 5);
      access(rd, wr, a, wd, sel, lat, oel, wel, fw, lw, ec);
      if (rd) exp_rd = lane_mask(ref_read(a), sel);
      else ref_write(a, wd, sel);
      check($sformatf("rnd%0d_latency", i), 32'(lat), rd ? 32'(W_A + 1) : 32'(W_A + 3));
      check($sformatf("rnd%0d_rd_data", i), 32'(rd_data_a), 32'(exp_rd));
      check($sformatf("rnd%0d_err", i), 32'(ec), (rd && wr) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("rnd_mem%0d", i), 32'(sram_a[16'h0400 + 16'(i)]), 32'(ref_read(16'h0400 + 16'(i))));

    // Single-cycle wait build, including a back-to-back read right after R
    use_b = 1'b1;
    access(1'b1, 1'b0, 16'h3000, 16'h0000, 2'b11, lat, oel, wel, fw, lw, ec);
    check("w1_read_latency", 32'(lat), 32'd2);
    check("w1_read_data", 32'(rd_data_b), 32'(init_val(16'h3000)));
    check("w1_read_oe_low", 32'(oel), 32'd1);
    access(1'b0, 1'b1, 16'h0100, 16'h0F0F, 2'b11, lat, oel, wel, fw, lw, ec);
    check("w1_write_latency", 32'(lat), 32'd4);
    check("w1_write_we_low", 32'(wel), 32'd1);
    check("w1_write_we_first", 32'(fw), 32'd1);
    access(1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11, lat, oel, wel, fw, lw, ec);
    check("w1_b2b_latency", 32'(lat), 32'd2);
    check("w1_b2b_data", 32'(rd_data_b), 32'h0F0F);
    use_b = 1'b0;

    check("protocol_violations", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
